or4_x2: RTL and testbench
=========================

# or4_x2

Four-input OR cell (drive-strength X2 class) with a registered observation stage. Combinational output ZN = A1 | A2 | A3 | A4 is the primary function and feeds downstream logic directly. A single-clock registered copy, an input snapshot and an optional rising-edge event counter let the cell be probed and characterised in-system without disturbing the combinational path.

## Interface
- CNT_W, 16, width of the rising-edge event counter (2..32).
- clk  input  1  sole clock; all registers rising-edge.
- rst  input  1  asynchronous, active-high reset.
- A1  input  1  OR operand, MSB of the input snapshot.
- A2  input  1  OR operand.
- A3  input  1  OR operand.
- A4  input  1  OR operand, LSB of the input snapshot.
- clr_cnt  input  1  synchronous clear of the event counter.
- ZN  output  1  combinational A1|A2|A3|A4.
- zn_q  output  1  ZN registered one cycle.
- src_q  output  4  registered {A1,A2,A3,A4}.
- rise_cnt  output  CNT_W  saturating count of ZN 0->1 transitions; present only with OR4_X2_STATS_EN.

## Operation
- ZN: pure combinational; no clock or reset dependency. ZN = 0 only for inputs 0000; 1 for all 15 other codes.
- X/Z on inputs: ZN follows standard 4-state OR (any input 1 forces ZN 1; otherwise an unknown input yields X). Registers are not protected from X.
- zn_q <= ZN every clk rising edge.
- src_q <= {A1,A2,A3,A4} every clk rising edge.
- Edge detect: rise = ZN & ~zn_q (zn_q serves as previous-cycle value).
- rise_cnt: clr_cnt=1 -> 0 (priority over increment); else rise=1 and rise_cnt < 2^CNT_W-1 -> +1; at all-ones it holds (saturates, no wrap).
- Reset (rst=1, asynchronous): zn_q=0, src_q=4'b0000, rise_cnt=0. ZN keeps tracking inputs during reset.
- First edge after reset release with ZN=1 counts as a rise (zn_q reset value 0).

## Timing
- ZN: zero-cycle, combinational from A1..A4.
- zn_q, src_q: one-cycle latency from inputs sampled at clk edge.
- rise_cnt: updates on the edge where zn_q still holds the old 0 and ZN=1; visible one cycle after ZN rises (sampled).
- Input pulses shorter than one clk period may be missed by registers and counter; ZN still reflects them.
- Reset asserted mid-operation clears registers immediately, independent of clk; deassertion is expected synchronous to clk by the integrator.
- clr_cnt and a rise on the same edge: result is 0.

## Configuration
- OR4_X2_STATS_EN defined: edge detector and rise_cnt register/port compiled in.
- Not defined: rise_cnt port absent, no counter logic; ZN, zn_q, src_q unchanged; clr_cnt remains as an ignored input.

## Structure
- Shared package or4_x2_pkg: CNT_W default constant, input-snapshot width constant (4), typedef for the snapshot vector.
- One sub-module is natural: or4_x2_evcnt (edge detect + saturating counter with clear), instantiated only under OR4_X2_STATS_EN.
- Combinational OR and the two sample registers stay in the top.

## Test plan
- Exhaustive truth table: drive all 16 codes 0000..1111, settle 10 time units each -> ZN=0 for 0000, ZN=1 for every other code.
- Registered path: apply 0000 then 0101 across one clk edge -> zn_q 0->1 and src_q=4'b0101 one cycle after inputs change.
- Reset: with inputs 1111 and zn_q=1, assert rst between edges -> zn_q=0, src_q=0000, rise_cnt=0 immediately; ZN stays 1.
- Counting (STATS_EN): toggle A3 0/1 for 5 full periods each -> rise_cnt=5; then clr_cnt=1 on the same edge as a rise -> rise_cnt=0.
- Saturation (CNT_W=2): generate 6 rising edges -> rise_cnt stops at 3.
- Build without OR4_X2_STATS_EN: same truth table and registered checks pass; rise_cnt port absent.

Source files
------------

// File: rtl/or4_x2_pkg.sv
// rtl/or4_x2_pkg.sv - shared constants and snapshot type for the or4_x2 cell
package or4_x2_pkg;
   localparam int CNT_W_DEF = 16;
   localparam int SRC_W     = 4;

   typedef logic [SRC_W-1:0] src_t;
endpackage

// File: rtl/or4_x2_evcnt.sv
// rtl/or4_x2_evcnt.sv - ZN rising-edge detector with saturating, clearable counter
module or4_x2_evcnt
   import or4_x2_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_zn,
   input  logic             i_zn_q,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);
   logic             w_rise;
   logic [CNT_W-1:0] r_cnt;

   // The registered copy of ZN doubles as the previous-cycle value.
   assign w_rise = i_zn & ~i_zn_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (w_rise && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/or4_x2.sv
// rtl/or4_x2.sv - four-input OR with registered observation stage
// Optional rise counter compiled in with OR4_X2_STATS_EN.
module or4_x2
   import or4_x2_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_a1,
   input  logic             i_a2,
   input  logic             i_a3,
   input  logic             i_a4,
   input  logic             i_clr_cnt,
   output logic             o_zn,
   output logic             o_zn_q,
   output logic [SRC_W-1:0] o_src_q
`ifdef OR4_X2_STATS_EN
   ,
   output logic [CNT_W-1:0] o_rise_cnt
`endif
);
   logic w_zn;
   src_t w_src;
   logic r_zn_q;
   src_t r_src_q;

   assign w_zn  = i_a1 | i_a2 | i_a3 | i_a4;
   assign w_src = {i_a1, i_a2, i_a3, i_a4};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_zn_q  <= 1'b0;
         r_src_q <= '0;
      end else begin
         r_zn_q  <= w_zn;
         r_src_q <= w_src;
      end
   end

   assign o_zn    = w_zn;
   assign o_zn_q  = r_zn_q;
   assign o_src_q = r_src_q;

`ifdef OR4_X2_STATS_EN
   or4_x2_evcnt #(
      .CNT_W (CNT_W)
   ) u_evcnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_zn   (w_zn),
      .i_zn_q (r_zn_q),
      .i_clr  (i_clr_cnt),
      .o_cnt  (o_rise_cnt)
   );
`else
   // Clear input and counter width are kept in the port list but go nowhere.
   logic [CNT_W-1:0] w_unused;
   assign w_unused = {CNT_W{i_clr_cnt}};
`endif
endmodule

// File: tb/tb_or4_x2.sv
// tb/tb_or4_x2.sv - self-checking bench for or4_x2 with directed vectors
module tb_or4_x2;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] din = 4'b0000;
   logic       clr = 1'b0;
   logic       zn, zn_q;
   logic [3:0] src_q;
   int         total = 0;
   int         bad   = 0;

   // Model state: last sampled inputs and rise counts for both widths.
   logic [3:0] m_src = 4'b0000;
   int         m_cnt16 = 0;
   int         m_cnt2  = 0;

   always #5 clk = ~clk;

`ifdef OR4_X2_STATS_EN
   logic [15:0] cnt16;
   logic [1:0]  cnt2;
   logic        zn_b, zn_q_b;
   logic [3:0]  src_q_b;

   or4_x2 #(.CNT_W(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_a1(din[3]), .i_a2(din[2]), .i_a3(din[1]),
      .i_a4(din[0]), .i_clr_cnt(clr), .o_zn(zn_b), .o_zn_q(zn_q_b),
      .o_src_q(src_q_b), .o_rise_cnt(cnt2)
   );
`endif

   or4_x2 #(.CNT_W(16)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_a1(din[3]), .i_a2(din[2]), .i_a3(din[1]),
      .i_a4(din[0]), .i_clr_cnt(clr), .o_zn(zn), .o_zn_q(zn_q), .o_src_q(src_q)
`ifdef OR4_X2_STATS_EN
      , .o_rise_cnt(cnt16)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: OR is "any bit set"; a rise is a sampled 0 followed by a sampled 1.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_src   = 4'b0000;
         m_cnt16 = 0;
         m_cnt2  = 0;
      end else begin
         if (clr) begin
            m_cnt16 = 0;
            m_cnt2  = 0;
         end else if ((din != 4'b0000) && (m_src == 4'b0000)) begin
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
            m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
         end
         m_src = din;
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("zn_live", {31'd0, zn}, {31'd0, din != 4'b0000});
      check("zn_q", {31'd0, zn_q}, {31'd0, m_src != 4'b0000});
      check("src_q", {28'd0, src_q}, {28'd0, m_src});
`ifdef OR4_X2_STATS_EN
      check("cnt16", {16'd0, cnt16}, m_cnt16);
      check("cnt2", {30'd0, cnt2}, m_cnt2);
      check("src_q_b", {28'd0, src_q_b}, {28'd0, m_src});
`endif
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      cyc(2);
      check("rst_zn_q", {31'd0, zn_q}, 32'd0);
      check("rst_src_q", {28'd0, src_q}, 32'd0);
      rst = 1'b0;
      cyc(1);

      // Exhaustive truth table, 10 time units per code.
      for (int c = 0; c < 16; c++) begin
         din = 4'(c);
         #10;
         check("truth", {31'd0, zn}, (c == 0) ? 32'd0 : 32'd1);
      end

      // Registered path: 0000 then 0101.
      din = 4'b0000;
      cyc(2);
      check("reg_zn_q0", {31'd0, zn_q}, 32'd0);
      din = 4'b0101;
      check("reg_zn_comb", {31'd0, zn}, 32'd1);
      check("reg_zn_q_hold", {31'd0, zn_q}, 32'd0);
      cyc(1);
      check("reg_zn_q1", {31'd0, zn_q}, 32'd1);
      check("reg_src_q", {28'd0, src_q}, 32'h5);
      din = 4'b1010;
      cyc(1);
      check("reg_src_q2", {28'd0, src_q}, 32'hA);

      // Asynchronous reset between edges.
      din = 4'b1111;
      cyc(1);
      check("pre_rst_zn_q", {31'd0, zn_q}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("async_zn_q", {31'd0, zn_q}, 32'd0);
      check("async_src_q", {28'd0, src_q}, 32'd0);
      check("async_zn", {31'd0, zn}, 32'd1);
`ifdef OR4_X2_STATS_EN
      check("async_cnt", {16'd0, cnt16}, 32'd0);
`endif
      cyc(1);
      rst = 1'b0;
      cyc(1);
      // First edge after release with ZN=1 is a rise.
      check("post_rst_src_q", {28'd0, src_q}, 32'hF);
`ifdef OR4_X2_STATS_EN
      check("post_rst_rise", {16'd0, cnt16}, 32'd1);
`endif

      // Counting: clear, then toggle A3 for 5 full periods.
      din = 4'b0000;
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      cyc(1);
      for (int k = 0; k < 5; k++) begin
         din = 4'b0010;
         cyc(1);
         din = 4'b0000;
         cyc(1);
      end
`ifdef OR4_X2_STATS_EN
      check("count5", {16'd0, cnt16}, 32'd5);
      check("count5_sat2", {30'd0, cnt2}, 32'd3);
`endif
      // Clear on the same edge as a rise.
      din = 4'b0010;
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
`ifdef OR4_X2_STATS_EN
      check("clr_vs_rise", {16'd0, cnt16}, 32'd0);
`endif
      cyc(1);
`ifdef OR4_X2_STATS_EN
      check("no_rise_held_high", {16'd0, cnt16}, 32'd0);
`endif

      // Saturation: six rises on the 2-bit counter.
      for (int k = 0; k < 6; k++) begin
         din = 4'b0000;
         cyc(1);
         din = 4'b1000;
         cyc(1);
      end
`ifdef OR4_X2_STATS_EN
      check("sat_cnt2", {30'd0, cnt2}, 32'd3);
      check("sat_cnt16", {16'd0, cnt16}, 32'd6);
`endif
      din = 4'b0000;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
